// File: rtl/ddr_wr_burst_ctrl.sv
// ddr_wr_burst_ctrl: FIFO-to-DDR write burst scheduler with linear frame addressing
// Define DDR_WR_BURST_CTRL_PINGPONG_EN to alternate between two frame buffers.
module ddr_wr_burst_ctrl #(
  parameter int DATA_WIDTH  = 256,
  parameter int LEVEL_WIDTH = 9,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_WIDTH  = 28,
  parameter int ADDR_BASE   = 0,
  parameter int FRAME_BEATS = 129600
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  input  logic                   fifo_rd_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   wr_req_valid,
  input  logic                   wr_req_ready,
  output logic [ADDR_WIDTH-1:0]  wr_req_addr,
  output logic [7:0]             wr_req_len,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_data_valid,
  input  logic                   wr_data_ready,
  output logic                   wr_data_last,
  output logic                   wr_buf_sel,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_underflow
);
  localparam int RW = $clog2(FRAME_BEATS + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BASE0 = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] BASE1 = BASE0 + ADDR_WIDTH'(FRAME_BEATS * (DATA_WIDTH / 8));
`ifdef DDR_WR_BURST_CTRL_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state, state_nx;

  logic [RW-1:0]         remaining;
  logic [BW-1:0]         beats_this, pop_cnt, beat_cnt;
  logic                  go_q, in_flight, fs_pend, wptr, rptr;
  logic [1:0]            skid_cnt;
  logic [DATA_WIDTH-1:0] skid [2];
  logic                  level_ok, deq, last_acc, frame_end, fs_apply;
  logic [ADDR_WIDTH-1:0] wrap_base;

  always_comb begin
    beats_this    = (remaining < RW'(BURST_LEN)) ? BW'(remaining) : BW'(BURST_LEN);
    level_ok      = enable && (fifo_rd_water_level >= LEVEL_WIDTH'(beats_this));
    busy          = state != IDLE;
    wr_req_valid  = state == REQ;
    wr_req_len    = wr_req_valid ? 8'(beats_this) - 8'd1 : 8'd0;
    wr_data_valid = skid_cnt != 2'd0;
    wr_data       = skid[rptr];
    wr_data_last  = wr_data_valid && ((beat_cnt + BW'(1)) == beats_this);
    deq           = wr_data_valid && wr_data_ready;
    last_acc      = deq && wr_data_last;
    // occupancy counts the head leaving this cycle so beats can stream back-to-back
    fifo_rd_en    = (state == DATA) && ((skid_cnt - 2'(deq) + 2'(in_flight)) < 2'd2) &&
                    (pop_cnt < beats_this);
    frame_end     = last_acc && (remaining == RW'(beats_this));
    fs_apply      = frame_start || fs_pend;
    wrap_base     = (PINGPONG && !wr_buf_sel) ? BASE1 : BASE0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (go_q && level_ok && !frame_start) ? REQ : IDLE;
      REQ:     state_nx = wr_req_ready ? DATA : REQ;
      DATA:    state_nx = last_acc ? IDLE : DATA;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_req_addr   <= BASE0;
      remaining     <= RW'(FRAME_BEATS);
      wr_buf_sel    <= 1'b0;
      fs_pend       <= 1'b0;
      go_q          <= 1'b0;
      in_flight     <= 1'b0;
      skid[0]       <= '0;
      skid[1]       <= '0;
      wptr          <= 1'b0;
      rptr          <= 1'b0;
      skid_cnt      <= 2'd0;
      pop_cnt       <= '0;
      beat_cnt      <= '0;
      frame_done    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nx;
      go_q          <= (state == IDLE) && level_ok;
      in_flight     <= fifo_rd_en;
      if (in_flight) skid[wptr] <= fifo_rd_data;
      wptr          <= wptr ^ in_flight;
      rptr          <= rptr ^ deq;
      skid_cnt      <= skid_cnt + 2'(in_flight) - 2'(deq);
      pop_cnt       <= (state == DATA && !last_acc) ? pop_cnt + BW'(fifo_rd_en) : '0;
      beat_cnt      <= (state == DATA && !last_acc) ? beat_cnt + BW'(deq) : '0;
      frame_done    <= frame_end;
      err_underflow <= err_underflow | (fifo_rd_en & fifo_rd_empty);
      if (last_acc && fs_apply) begin
        wr_req_addr <= BASE0;
        remaining   <= RW'(FRAME_BEATS);
        wr_buf_sel  <= 1'b0;
        fs_pend     <= 1'b0;
      end else if (frame_end) begin
        wr_req_addr <= wrap_base;
        remaining   <= RW'(FRAME_BEATS);
        wr_buf_sel  <= PINGPONG & ~wr_buf_sel;
      end else if (last_acc) begin
        wr_req_addr <= wr_req_addr + ADDR_WIDTH'(beats_this) * BEAT_BYTES;
        remaining   <= remaining - RW'(beats_this);
      end else if (frame_start && state == IDLE) begin
        wr_req_addr <= BASE0;
        remaining   <= RW'(FRAME_BEATS);
        wr_buf_sel  <= 1'b0;
      end else if (frame_start) begin
        fs_pend     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// tb_ddr_wr_burst_ctrl: directed bench for ddr_wr_burst_ctrl with a small FIFO source model
module tb_ddr_wr_burst_ctrl;
  logic         clk = 1'b0;
  logic         rst_n, enable, frame_start, fifo_rd_empty, fifo_rd_en;
  logic [8:0]   level;
  logic [255:0] fifo_rd_data = '0;
  logic         wr_req_valid, wr_req_ready, wr_data_valid, wr_data_ready, wr_data_last;
  logic [27:0]  wr_req_addr;
  logic [7:0]   wr_req_len;
  logic [255:0] wr_data;
  logic         wr_buf_sel, busy, frame_done, err_underflow;

`ifdef DDR_WR_BURST_CTRL_PINGPONG_EN
  localparam logic [27:0] F1 = 28'h500;
`else
  localparam logic [27:0] F1 = 28'h0;
`endif

  ddr_wr_burst_ctrl #(
    .DATA_WIDTH(256), .LEVEL_WIDTH(9), .BURST_LEN(16), .ADDR_WIDTH(28),
    .ADDR_BASE(0), .FRAME_BEATS(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .fifo_rd_water_level(level), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data_last(wr_data_last),
    .wr_buf_sel(wr_buf_sel), .busy(busy), .frame_done(frame_done), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int seq = 0, exp_seq = 0, bidx = 0, ahead = 0, an = 0, beats = 0, fd_cnt = 0;
  logic [7:0]   cur_len = 8'd0;
  logic         pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [255:0] pd = '0;

  function automatic logic [255:0] pat(input int n);
    return {8{32'hC0DE0000 + 32'(n)}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [27:0] ea, input logic [7:0] el, input string tag);
    int n = 0;
    while (!wr_req_valid && n < 300) begin
      step();
      n++;
    end
    check({tag, "_valid"}, wr_req_valid, 1'b1);
    check({tag, "_addr"}, wr_req_addr, ea);
    check({tag, "_len"}, wr_req_len, el);
    step();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // FIFO source: data appears one cycle after each pop, in sequence order
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= pat(seq);
      seq <= seq + 1;
    end
  end

  // Beat scoreboard, stall stability and pop-ahead limit
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_seq = seq;
      bidx = 0;
      ahead = 0;
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("stall_valid", wr_data_valid, 1'b1);
        check("stall_data", wr_data, pd);
        check("stall_last", wr_data_last, pl);
      end
      if (wr_req_valid && wr_req_ready) cur_len = wr_req_len;
      an = ahead + int'(fifo_rd_en) - int'(wr_data_valid && wr_data_ready);
      if (fifo_rd_en) check("pop_ahead_le2", an <= 2, 1'b1);
      ahead = an;
      if (wr_data_valid && wr_data_ready) begin
        check("beat_data", wr_data, pat(exp_seq));
        check("beat_last", wr_data_last, bidx == int'(cur_len));
        exp_seq++;
        beats++;
        bidx = (bidx == int'(cur_len)) ? 0 : bidx + 1;
      end
      if (frame_done) fd_cnt++;
      pv = wr_data_valid;
      pr = wr_data_ready;
      pd = wr_data;
      pl = wr_data_last;
    end
  end

  initial begin
    int s0, b0, k;
    logic any;
    logic [3:0] rp;
    rp = 4'b1001;
    rst_n = 1'b0;
    enable = 1'b0;
    frame_start = 1'b0;
    level = 9'd0;
    fifo_rd_empty = 1'b0;
    wr_req_ready = 1'b1;
    wr_data_ready = 1'b1;
    repeat (3) step();
    check("rst_req_valid", wr_req_valid, 1'b0);
    check("rst_req_addr", wr_req_addr, 28'h0);
    check("rst_req_len", wr_req_len, 8'd0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_data", wr_data, 256'h0);
    check("rst_data_valid", wr_data_valid, 1'b0);
    check("rst_data_last", wr_data_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err", err_underflow, 1'b0);
    check("rst_sel", wr_buf_sel, 1'b0);
    rst_n = 1'b1;
    step();
    enable = 1'b1;
    level = 9'd40;
    wait_req(28'h0, 8'd15, "f0b0");
    wait_req(28'h200, 8'd15, "f0b1");
    wait_req(28'h400, 8'd7, "f0b2");
    wait_done("f0");
    step();
    step();
    check("frame_done_cnt", fd_cnt, 1);
    check("frame_beats", beats, 40);
    check("frame_sel", wr_buf_sel, F1 != 28'h0);
    wait_req(F1, 8'd15, "f1b0");
    enable = 1'b0;
    wait_done("f1b0");
    any = 1'b0;
    repeat (8) begin
      step();
      any |= wr_req_valid;
    end
    check("en_off_noreq", any, 1'b0);
    level = 9'd15;
    enable = 1'b1;
    any = 1'b0;
    repeat (8) begin
      step();
      any |= wr_req_valid;
    end
    check("lvl15_noreq", any, 1'b0);
    s0 = seq;
    level = 9'd16;
    step();
    check("lvl16_cyc1", wr_req_valid, 1'b0);
    step();
    check("lvl16_cyc2", wr_req_valid, 1'b1);
    wait_req(F1 + 28'h200, 8'd15, "lvl16");
    wait_done("lvl16");
    check("lvl16_pops", seq - s0, 16);
    enable = 1'b0;
    level = 9'd40;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    enable = 1'b1;
    wait_req(28'h0, 8'd15, "bp");
    b0 = beats;
    k = 0;
    while (busy && k < 300) begin
      wr_data_ready = rp[k % 4];
      step();
      k++;
    end
    wr_data_ready = 1'b1;
    check("bp_idle", busy, 1'b0);
    check("bp_beats", beats - b0, 16);
    wait_req(28'h200, 8'd15, "fs_b1");
    b0 = beats;
    step();
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_done("fs_b1");
    check("fs_b1_beats", beats - b0, 16);
    wait_req(28'h0, 8'd15, "fs_next");
    wait_req(28'h200, 8'd15, "fs_rem");
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid", wr_req_valid, 1'b0);
    check("mid_rst_addr", wr_req_addr, 28'h0);
    check("mid_rst_rd_en", fifo_rd_en, 1'b0);
    check("mid_rst_data", wr_data, 256'h0);
    check("mid_rst_data_valid", wr_data_valid, 1'b0);
    check("mid_rst_last", wr_data_last, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err_underflow, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_req(28'h0, 8'd15, "post_rst");
`ifdef DDR_WR_BURST_CTRL_PINGPONG_EN
    wait_req(28'h200, 8'd15, "pp_f0b1");
    wait_req(28'h400, 8'd7, "pp_f0b2");
    wait_req(28'h500, 8'd15, "pp_f1b0");
    check("pp_sel1", wr_buf_sel, 1'b1);
    wait_req(28'h700, 8'd15, "pp_f1b1");
    wait_req(28'h900, 8'd7, "pp_f1b2");
    wait_req(28'h0, 8'd15, "pp_f2b0");
    check("pp_sel0", wr_buf_sel, 1'b0);
`endif
    enable = 1'b0;
    wait_done("final");
    check("err_underflow", err_underflow, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
